// File: rtl/ariane_pkg.sv
// ariane_pkg -- shared core types and constants used by the CSR commit path.
//   XLEN               : datapath width of CSR operands and results
//   fu_op              : functional-unit operation encoding
//   ILLEGAL_INSTR      : exception cause for an illegal CSR access
//   LP_VIOLATION_CAUSE : exception cause for a landing-pad label mismatch
//   CSR_TIMEOUT_CAUSE  : exception cause for a CSR file that never responds
package ariane_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [XLEN-1:0] ILLEGAL_INSTR      = 64'd2;
    localparam logic [XLEN-1:0] LP_VIOLATION_CAUSE = 64'd18;
    localparam logic [XLEN-1:0] CSR_TIMEOUT_CAUSE  = 64'd24;

    typedef enum logic [7:0] {
        ADD,
        SUB,
        CSR_WRITE,
        CSR_READ,
        CSR_SET,
        CSR_CLEAR,
        LPCLL
    } fu_op;

endpackage

// File: rtl/csr_commit_ctrl_watchdog.sv
// csr_resp_watchdog -- saturating cycle counter for an outstanding CSR response.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : count this cycle (controller is waiting for a response)
//   clr_i         : return the count to zero
//   timeout_o     : asserted during the Timeout-th enabled cycle and after
module csr_resp_watchdog #(
    parameter int unsigned Timeout = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic timeout_o
);

    localparam int unsigned    CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Timeout - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != Last)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_o = en_i && (cnt_q == Last);

endmodule

// File: rtl/csr_commit_ctrl.sv
// csr_commit_ctrl -- retires a CSR-class instruction at the scoreboard head by
// issuing one request to the CSR file and returning its result or exception.
//   flush_i, commit_valid_i, commit_op_i, commit_wdata_i, csr_addr_i : commit side
//   csr_commit_o                                    : pulse on grant, frees FU entry
//   csr_req_o, csr_op_o, csr_waddr_o, csr_wdata_o  : request to CSR file
//   csr_gnt_i, csr_rvalid_i, csr_rdata_i, csr_ex_i : CSR file handshake/response
//   wb_valid_o, wb_data_o, ex_valid_o, ex_cause_o  : one-cycle retire result
// Build option: define FCFI_LP_CHECK_EN to compare landing-pad labels on LPCLL.
module csr_commit_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned RespTimeout = 16,
    parameter int unsigned LabelW      = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            commit_valid_i,
    input  fu_op            commit_op_i,
    input  logic [XLEN-1:0] commit_wdata_i,
    input  logic [11:0]     csr_addr_i,
    output logic            csr_commit_o,
    output logic            csr_req_o,
    output fu_op            csr_op_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic            csr_gnt_i,
    input  logic            csr_rvalid_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic            csr_ex_i,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_cause_o
);

    if (RespTimeout == 0) begin : g_bad_timeout
        $error("RespTimeout must be at least 1");
    end
    if ((LabelW == 0) || (LabelW > XLEN)) begin : g_bad_labelw
        $error("LabelW must be in 1..XLEN");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e          state_q, state_d;
    fu_op            op_q, op_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [11:0]     addr_q, addr_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic            ex_q, ex_d;
    logic            drain_q, drain_d;
    logic            timeout;
    logic            lp_mismatch;

    csr_resp_watchdog #(
        .Timeout(RespTimeout)
    ) i_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (state_q == WAIT),
        .clr_i    (state_q != WAIT),
        .timeout_o(timeout)
    );

`ifdef FCFI_LP_CHECK_EN
    assign lp_mismatch = (op_q == LPCLL) &&
                         (csr_rdata_i[LabelW-1:0] != wdata_q[LabelW-1:0]);
`else
    assign lp_mismatch = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        cause_d      = cause_q;
        ex_d         = ex_q;
        drain_d      = drain_q;
        csr_commit_o = 1'b0;
        csr_req_o    = 1'b0;
        csr_op_o     = ADD;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        wb_valid_o   = 1'b0;
        wb_data_o    = '0;
        ex_valid_o   = 1'b0;
        ex_cause_o   = '0;

        unique case (state_q)
            IDLE: begin
                drain_d = 1'b0;
                if (commit_valid_i) begin
                    op_d    = commit_op_i;
                    wdata_d = commit_wdata_i;
                    addr_d  = csr_addr_i;
                    state_d = REQ;
                end
            end

            REQ: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    csr_req_o   = 1'b1;
                    csr_op_o    = op_q;
                    csr_waddr_o = addr_q;
                    csr_wdata_o = wdata_q;
                    if (csr_gnt_i) begin
                        csr_commit_o = 1'b1;
                        state_d      = WAIT;
                        if (csr_rvalid_i) begin
                            rdata_d = csr_rdata_i;
                            ex_d    = csr_ex_i | lp_mismatch;
                            cause_d = csr_ex_i    ? ILLEGAL_INSTR :
                                      lp_mismatch ? LP_VIOLATION_CAUSE : '0;
                            state_d = DONE;
                        end
                    end
                end
            end

            WAIT: begin
                // A flushed access still has to be drained from the CSR file;
                // its response is consumed here and never reported.
                if (flush_i) begin
                    drain_d = 1'b1;
                end
                if (csr_rvalid_i) begin
                    rdata_d = csr_rdata_i;
                    ex_d    = csr_ex_i | lp_mismatch;
                    cause_d = csr_ex_i    ? ILLEGAL_INSTR :
                              lp_mismatch ? LP_VIOLATION_CAUSE : '0;
                    state_d = (drain_q || flush_i) ? IDLE : DONE;
                end else if (timeout) begin
                    rdata_d = '0;
                    ex_d    = 1'b1;
                    cause_d = CSR_TIMEOUT_CAUSE;
                    state_d = (drain_q || flush_i) ? IDLE : DONE;
                end
            end

            DONE: begin
                if (!flush_i) begin
                    if (ex_q) begin
                        ex_valid_o = 1'b1;
                        ex_cause_o = cause_q;
                    end else begin
                        wb_valid_o = 1'b1;
                        wb_data_o  = rdata_q;
                    end
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= ADD;
            wdata_q <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            cause_q <= '0;
            ex_q    <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            cause_q <= cause_d;
            ex_q    <= ex_d;
            drain_q <= drain_d;
        end
    end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// tb_csr_commit_ctrl -- directed bench for csr_commit_ctrl with a result
// scoreboard. Expectations for LPCLL follow FCFI_LP_CHECK_EN.
module tb_csr_commit_ctrl;
    import ariane_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            commit_valid = 1'b0;
    fu_op            commit_op = ADD;
    logic [XLEN-1:0] commit_wdata = '0;
    logic [11:0]     commit_addr = '0;
    logic            gnt = 1'b0;
    logic            rvalid = 1'b0;
    logic [XLEN-1:0] rdata = '0;
    logic            cex = 1'b0;

    logic            csr_commit_o, csr_req_o, wb_valid_o, ex_valid_o;
    fu_op            csr_op_o;
    logic [11:0]     csr_waddr_o;
    logic [XLEN-1:0] csr_wdata_o, wb_data_o, ex_cause_o;

    typedef struct {
        logic            is_ex;
        logic [XLEN-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_push = 0;
    int   out_cnt = 0;
    int   commit_cnt = 0;
    int   commit_exp = 0;

    csr_commit_ctrl #(
        .RespTimeout(16),
        .LabelW     (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .commit_valid_i(commit_valid),
        .commit_op_i   (commit_op),
        .commit_wdata_i(commit_wdata),
        .csr_addr_i    (commit_addr),
        .csr_commit_o  (csr_commit_o),
        .csr_req_o     (csr_req_o),
        .csr_op_o      (csr_op_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .csr_gnt_i     (gnt),
        .csr_rvalid_i  (rvalid),
        .csr_rdata_i   (rdata),
        .csr_ex_i      (cex),
        .wb_valid_o    (wb_valid_o),
        .wb_data_o     (wb_data_o),
        .ex_valid_o    (ex_valid_o),
        .ex_cause_o    (ex_cause_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_ex, input logic [XLEN-1:0] val);
        exp_t e;
        e.is_ex = is_ex;
        e.val   = val;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic start(input fu_op op, input logic [11:0] addr, input logic [XLEN-1:0] wd);
        commit_valid = 1'b1;
        commit_op    = op;
        commit_addr  = addr;
        commit_wdata = wd;
        cyc();
        commit_valid = 1'b0;
    endtask

    // Scoreboard: every retire output pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_commit_o) commit_cnt++;
            if (wb_valid_o || ex_valid_o) begin
                out_cnt++;
                chk("wb_ex_exclusive", {63'd0, wb_valid_o & ex_valid_o}, 64'd0);
                chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_kind", {63'd0, ex_valid_o}, {63'd0, e.is_ex});
                    chk("out_val", ex_valid_o ? ex_cause_o : wb_data_o, e.val);
                end
            end
        end
    end

    initial begin
        int waited;
        logic found;

        // reset state
        repeat (3) cyc();
        @(negedge clk);
        chk("reset_outs", {63'd0, |{csr_commit_o, csr_req_o, csr_op_o, csr_waddr_o, csr_wdata_o,
                                     wb_valid_o, wb_data_o, ex_valid_o, ex_cause_o}}, 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // plain write, minimum latency
        push(1'b0, 64'h9);
        start(CSR_WRITE, 12'h340, 64'h5);
        gnt = 1'b1; rvalid = 1'b1; rdata = 64'h9;
        commit_exp++;
        @(negedge clk);
        chk("t1_req", {63'd0, csr_req_o}, 64'd1);
        chk("t1_op", {56'd0, csr_op_o}, {56'd0, CSR_WRITE});
        chk("t1_addr", {52'd0, csr_waddr_o}, 64'h340);
        chk("t1_wdata", csr_wdata_o, 64'h5);
        chk("t1_commit", {63'd0, csr_commit_o}, 64'd1);
        cyc();
        gnt = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        chk("t1_wb_cycle3", {63'd0, wb_valid_o}, 64'd1);
        cyc();
        @(negedge clk);
        chk("t1_wb_once", {63'd0, wb_valid_o}, 64'd0);
        chk("t1_commit_once", commit_cnt, commit_exp);

        // delayed grant and response; commit_valid outside IDLE is ignored
        push(1'b0, 64'h77);
        start(CSR_SET, 12'h300, 64'hA5);
        commit_valid = 1'b1; commit_addr = 12'h7FF; commit_wdata = 64'hFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_req_held", {63'd0, csr_req_o}, 64'd1);
            chk("t2_addr_stable", {52'd0, csr_waddr_o}, 64'h300);
            chk("t2_wdata_stable", csr_wdata_o, 64'hA5);
            chk("t2_no_commit", {63'd0, csr_commit_o}, 64'd0);
            cyc();
        end
        commit_valid = 1'b0;
        gnt = 1'b1;
        commit_exp++;
        @(negedge clk);
        chk("t2_commit", {63'd0, csr_commit_o}, 64'd1);
        cyc();
        gnt = 1'b0;
        @(negedge clk);
        chk("t2_req_dropped", {63'd0, csr_req_o}, 64'd0);
        cyc(); cyc();
        rvalid = 1'b1; rdata = 64'h77;
        cyc();
        rvalid = 1'b0;
        cyc(); cyc();
        chk("t2_single_wb", out_cnt, n_push);

        // response timeout
        push(1'b1, CSR_TIMEOUT_CAUSE);
        start(CSR_READ, 12'hC00, 64'h0);
        gnt = 1'b1;
        commit_exp++;
        cyc();
        gnt = 1'b0;
        found = 1'b0; waited = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ex_valid_o) begin
                waited = k; found = 1'b1;
                break;
            end
            cyc();
        end
        chk("t3_timeout_seen", {63'd0, found}, 64'd1);
        chk("t3_timeout_latency", waited, 17);
        cyc();
        @(negedge clk);
        chk("t3_idle_after", {62'd0, csr_req_o, ex_valid_o}, 64'd0);

        // flush in REQ
        start(CSR_WRITE, 12'h305, 64'h1);
        flush = 1'b1; gnt = 1'b1;
        @(negedge clk);
        chk("t4_flush_no_commit", {63'd0, csr_commit_o}, 64'd0);
        cyc();
        flush = 1'b0; gnt = 1'b0;
        @(negedge clk);
        chk("t4_flush_idle", {63'd0, csr_req_o}, 64'd0);

        // flush in WAIT, then response: drained silently
        cyc();
        start(CSR_WRITE, 12'h306, 64'h2);
        gnt = 1'b1;
        commit_exp++;
        cyc();
        gnt = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        rvalid = 1'b1; rdata = 64'hBAD;
        cyc();
        rvalid = 1'b0;
        repeat (3) cyc();
        chk("t5_drain_silent", out_cnt, n_push);

        // flush in DONE
        start(CSR_READ, 12'h307, 64'h3);
        gnt = 1'b1; rvalid = 1'b1; rdata = 64'h33;
        commit_exp++;
        cyc();
        gnt = 1'b0; rvalid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("t6_flush_done", {62'd0, wb_valid_o, ex_valid_o}, 64'd0);
        cyc();
        flush = 1'b0;

        // illegal access
        push(1'b1, ILLEGAL_INSTR);
        start(CSR_WRITE, 12'hF11, 64'h4);
        gnt = 1'b1; rvalid = 1'b1; cex = 1'b1; rdata = 64'h44;
        commit_exp++;
        cyc();
        gnt = 1'b0; rvalid = 1'b0; cex = 1'b0;
        @(negedge clk);
        chk("t7_no_wb", {63'd0, wb_valid_o}, 64'd0);
        cyc();

        // LPCLL label mismatch then match
`ifdef FCFI_LP_CHECK_EN
        push(1'b1, LP_VIOLATION_CAUSE);
`else
        push(1'b0, 64'h12);
`endif
        start(LPCLL, 12'h800, 64'h13);
        gnt = 1'b1; rvalid = 1'b1; rdata = 64'h12;
        commit_exp++;
        cyc();
        gnt = 1'b0; rvalid = 1'b0;
        cyc();
        push(1'b0, 64'hAB13);
        start(LPCLL, 12'h800, 64'h13);
        gnt = 1'b1; rvalid = 1'b1; rdata = 64'hAB13;
        commit_exp++;
        cyc();
        gnt = 1'b0; rvalid = 1'b0;
        cyc();

        // response in the timeout cycle wins
        push(1'b0, 64'h55);
        start(CSR_READ, 12'hC01, 64'h0);
        gnt = 1'b1;
        commit_exp++;
        cyc();
        gnt = 1'b0;
        repeat (15) cyc();
        rvalid = 1'b1; rdata = 64'h55;
        cyc();
        rvalid = 1'b0;
        @(negedge clk);
        chk("t8_rvalid_wins", {62'd0, wb_valid_o, ex_valid_o}, 64'b10);
        cyc();

        // reset during WAIT
        start(CSR_WRITE, 12'h340, 64'h6);
        gnt = 1'b1;
        commit_exp++;
        cyc();
        gnt = 1'b0;
        cyc();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t9_rst_outs", {63'd0, |{csr_commit_o, csr_req_o, csr_op_o, csr_waddr_o, csr_wdata_o,
                                      wb_valid_o, wb_data_o, ex_valid_o, ex_cause_o}}, 64'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        rvalid = 1'b1; rdata = 64'hDEAD;
        cyc();
        rvalid = 1'b0;
        @(negedge clk);
        chk("t9_no_stale_out", {62'd0, wb_valid_o, ex_valid_o}, 64'd0);
        cyc();

        // controller is back in IDLE and serves a fresh access
        push(1'b0, 64'hC0DE);
        start(CSR_CLEAR, 12'h341, 64'h7);
        gnt = 1'b1; rvalid = 1'b1; rdata = 64'hC0DE;
        commit_exp++;
        cyc();
        gnt = 1'b0; rvalid = 1'b0;
        repeat (3) cyc();

        chk("out_total", out_cnt, n_push);
        chk("commit_total", commit_cnt, commit_exp);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/csr_commit_ctrl.md
CSR_COMMIT_CTRL -- requirements
Module: csr_commit_ctrl

Interface
REQ-001 SHALL have parameter RespTimeout, default 16: cycles allowed from grant to csr_rvalid_i before a timeout fault.
REQ-002 SHALL have parameter LabelW, default 8: landing-pad label width in bits compared by LPCLL.
REQ-003 SHALL have port clk_i, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i, input, 1: pipeline flush.
REQ-006 SHALL have port commit_valid_i, input, 1: scoreboard head is a CSR-class instruction ready to retire.
REQ-007 SHALL have port commit_op_i, input, fu_op: operation of the head instruction.
REQ-008 SHALL have port commit_wdata_i, input, xlen: operand captured by the CSR functional unit.
REQ-009 SHALL have port csr_addr_i, input, 12: pending CSR address from the CSR functional unit buffer.
REQ-010 SHALL have port csr_commit_o, output, 1: one-cycle pulse releasing the functional unit's pending entry.
REQ-011 SHALL have ports csr_req_o (output, 1), csr_op_o (output, fu_op), csr_waddr_o (output, 12) and csr_wdata_o (output, xlen): request to the CSR file.
REQ-012 SHALL have ports csr_gnt_i (input, 1), csr_rvalid_i (input, 1), csr_rdata_i (input, xlen) and csr_ex_i (input, 1): CSR file grant, response valid, old CSR value, and illegal-access flag.
REQ-013 SHALL have ports wb_valid_o (output, 1), wb_data_o (output, xlen), ex_valid_o (output, 1) and ex_cause_o (output, xlen): retire result or exception to commit.

Function
REQ-014 SHALL implement states IDLE, REQ, WAIT, DONE.
REQ-015 IDLE: on commit_valid_i, SHALL latch commit_op_i, commit_wdata_i and csr_addr_i and move to REQ next cycle.
REQ-016 REQ: SHALL hold csr_req_o=1 with the latched op, address and data stable until csr_gnt_i; on grant SHALL move to WAIT.
REQ-017 SHALL pulse csr_commit_o for exactly the grant cycle, never otherwise.
REQ-018 WAIT: on csr_rvalid_i SHALL latch csr_rdata_i and csr_ex_i and move to DONE; grant and rvalid in the same cycle SHALL skip WAIT and go directly to DONE.
REQ-019 WAIT: a saturating counter SHALL count cycles in WAIT; reaching RespTimeout SHALL enter DONE with a fault, cause CSR_TIMEOUT_CAUSE.
REQ-020 DONE: for exactly one cycle SHALL assert either wb_valid_o with wb_data_o = latched rdata, or ex_valid_o with ex_cause_o; never both; then return to IDLE.
REQ-021 csr_ex_i=1 SHALL produce ex_valid_o with cause ILLEGAL_INSTR; wb_valid_o SHALL stay 0.
REQ-022 Minimum latency commit_valid_i to wb_valid_o SHALL be 3 cycles (grant and rvalid both in the first REQ cycle).
REQ-023 commit_valid_i outside IDLE SHALL be ignored.
REQ-024 flush_i in REQ SHALL drop the request, return to IDLE and not pulse csr_commit_o.
REQ-025 flush_i in WAIT SHALL enter DRAIN behaviour: remain in WAIT until rvalid or timeout, then return to IDLE with no wb/ex output.
REQ-026 flush_i in DONE SHALL suppress wb_valid_o and ex_valid_o.
REQ-027 Timeout and rvalid in the same cycle SHALL be treated as rvalid.

Reset
REQ-028 On reset SHALL enter IDLE, clear the counter and latches, and drive every output to 0.
REQ-029 Reset during REQ, WAIT or DONE SHALL abandon the operation with no output pulse.

Configuration
REQ-030 With FCFI_LP_CHECK_EN defined, an LPCLL response SHALL compare rdata[LabelW-1:0] against wdata[LabelW-1:0]; a mismatch SHALL raise ex_valid_o with cause LP_VIOLATION_CAUSE.
REQ-031 Without FCFI_LP_CHECK_EN, LPCLL SHALL behave as an ordinary CSR access with no compare; LabelW is then unused.

Structure
REQ-032 CSR_TIMEOUT_CAUSE and LP_VIOLATION_CAUSE SHALL be defined in ariane_pkg; fu_op SHALL be reused from ariane_pkg.
REQ-033 SHALL contain one sub-module, csr_resp_watchdog, holding the timeout counter.

Verification
REQ-034 Plain CSR write: commit_valid_i with addr 0x340, wdata 0x5; gnt+rvalid same cycle, rdata 0x9 -> csr_commit_o 1 pulse; wb_valid_o with 0x9 in cycle 3.
REQ-035 Delayed response: gnt at +2, rvalid at +5 -> csr_req_o held stable until gnt; a single wb pulse.
REQ-036 Timeout: no rvalid for 16 cycles -> ex_valid_o, cause CSR_TIMEOUT_CAUSE, return to IDLE.
REQ-037 Flush in REQ -> no csr_commit_o; flush in WAIT followed by rvalid -> no wb/ex output.
REQ-038 FCFI_LP_CHECK_EN, LPCLL, LabelW=8: rdata 0x12 vs wdata 0x13 -> ex LP_VIOLATION_CAUSE; with equal labels -> wb_valid_o.
REQ-039 csr_ex_i=1 with rvalid -> ex_valid_o cause ILLEGAL_INSTR; reset asserted mid-WAIT -> all outputs 0 and state IDLE.
